// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, control/status
// bit positions and bus FSM state encoding.
package mmio_pkg;

    localparam logic [7:0] OffLed    = 8'h00;
    localparam logic [7:0] OffSw     = 8'h04;
    localparam logic [7:0] OffTcount = 8'h08;
    localparam logic [7:0] OffTcmp   = 8'h0C;
    localparam logic [7:0] OffCtrl   = 8'h10;
    localparam logic [7:0] OffStatus = 8'h14;

    localparam int unsigned CtrlTimerEn = 0;
    localparam int unsigned CtrlIrqEn   = 1;
    localparam int unsigned StatusMatch = 0;

    typedef logic [0:0] state_t;
    localparam state_t StIdle = 1'b0;
    localparam state_t StResp = 1'b1;

endpackage

// File: rtl/mmio_timer.sv
// Free-running compare timer: counts while enabled, rolls to zero on compare
// and latches a sticky match flag.
module mmio_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        timer_en,
    input  logic        cnt_we,
    input  logic [31:0] cnt_wdata,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        match_clr,
    output logic [31:0] tcount,
    output logic [31:0] tcmp,
    output logic        match
);

    logic [31:0] tcount_q, tcount_d;
    logic [31:0] tcmp_q, tcmp_d;
    logic        match_q, match_d;
    logic        hit;

    // A software write to TCOUNT pre-empts both the increment and the compare.
    assign hit = timer_en && !cnt_we && (tcount_q == tcmp_q);

    always_comb begin
        tcount_d = tcount_q;
        if (cnt_we) begin
            tcount_d = cnt_wdata;
        end else if (hit) begin
            tcount_d = '0;
        end else if (timer_en) begin
            tcount_d = tcount_q + 32'd1;
        end
    end

    assign tcmp_d  = cmp_we ? cmp_wdata : tcmp_q;
    // Set beats a simultaneous write-1-to-clear.
    assign match_d = hit ? 1'b1 : (match_clr ? 1'b0 : match_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcount_q <= '0;
            tcmp_q   <= 32'hFFFF_FFFF;
            match_q  <= 1'b0;
        end else begin
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            match_q  <= match_d;
        end
    end

    assign tcount = tcount_q;
    assign tcmp   = tcmp_q;
    assign match  = match_q;

endmodule

// File: rtl/mmio_responder.sv
// Single-outstanding MMIO slave exposing LEDs, synchronized switches and a
// compare timer with level interrupt.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [3:0]  switches,
    output logic [3:0]  leds,
    output logic        irq
);

    state_t      state_q, state_d;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [3:0]  led_q;
    logic [1:0]  ctrl_q;
    logic [3:0]  sync_q [SYNC_STAGES];

    logic        accept;
    logic [31:0] offset;
    logic [7:0]  reg_off;
    logic        addr_err;
    logic        wr_en;
    logic [31:0] rd_data;
    logic [31:0] tcount, tcmp;
    logic        match;

    assign accept  = (state_q == StIdle) && req_valid;
    // Unsigned offset: addresses below the base wrap to large values and fail the window test.
    assign offset  = req_addr - BASE_ADDR;
    assign reg_off = offset[7:0];
    assign addr_err = (req_addr[1:0] != 2'b00) || (offset[31:8] != 24'd0) || (reg_off > OffStatus);
    assign wr_en   = accept && req_write && !addr_err;

    always_comb begin
        rd_data = '0;
        case (reg_off)
            OffLed:    rd_data = {28'd0, led_q};
            OffSw:     rd_data = {28'd0, sync_q[SYNC_STAGES-1]};
            OffTcount: rd_data = tcount;
            OffTcmp:   rd_data = tcmp;
            OffCtrl:   rd_data = {30'd0, ctrl_q};
            OffStatus: rd_data = {31'd0, match};
            default:   rd_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= switches;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            led_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_rdata_q <= (req_write || addr_err) ? 32'd0 : rd_data;
                rsp_err_q   <= addr_err;
            end
            if (wr_en && reg_off == OffLed) led_q <= req_wdata[3:0];
            if (wr_en && reg_off == OffCtrl) ctrl_q <= req_wdata[1:0];
        end
    end

    mmio_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .timer_en  (ctrl_q[CtrlTimerEn]),
        .cnt_we    (wr_en && reg_off == OffTcount),
        .cnt_wdata (req_wdata),
        .cmp_we    (wr_en && reg_off == OffTcmp),
        .cmp_wdata (req_wdata),
        .match_clr (wr_en && reg_off == OffStatus && req_wdata[StatusMatch]),
        .tcount    (tcount),
        .tcmp      (tcmp),
        .match     (match)
    );

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign leds      = led_q;
    assign irq       = match & ctrl_q[CtrlIrqEn];

endmodule
